modular_mult_initiator: RTL
===========================

# modular_mult_initiator

Initiator side of the modular-reduction start/done interface. The block accepts operand pairs a, b modulo q = 8380417 (Dilithium) over a valid/ready handshake and range-corrects each operand. It forms the 46-bit product, launches it into the fixed-modulus Barrett reduction engine with a single-cycle start pulse, and waits for done. It then returns the reduced result downstream, and a watchdog flags a reducer that never answers.

## Interface
- Q_WIDTH, 23, operand/result width.
- DATA_WIDTH, 48, width of the product word driven to the reducer.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before the watchdog fires (≥ 8).
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a, in_b  input  Q_WIDTH  operands, any value in [0, 2^23).
- red_start  output  1  one-cycle launch pulse to reducer.
- red_data  output  DATA_WIDTH  product, zero-extended from 46 bits.
- red_done  input  1  reducer completion pulse.
- red_result  input  Q_WIDTH  reducer output, sampled only while red_done = 1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  Q_WIDTH  (a·b) mod q.
- out_err  output  1  qualifies out_data; 1 = watchdog timeout, and out_data = 0.

## Operation
- States: IDLE, PRE, MUL, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid, register in_a and in_b, then go to PRE.
- PRE:
  - Range-correct each operand: if x ≥ q then x ← x − q (one subtraction suffices, since 2^23 < 2q).
  - Go to MUL.
- MUL:
  - Register the full 46-bit product a·b.
  - Go to ISSUE.
- ISSUE:
  - red_start = 1 for exactly this cycle; red_data = product.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - red_start = 0. The counter increments each cycle.
  - red_done = 1: capture red_result into out_data, out_err ← 0, go to OUT.
  - Else if the counter reaches TIMEOUT_CYCLES−1: out_data ← 0, out_err ← 1, go to OUT.
  - If red_done and the timeout coincide, red_done wins.
- OUT:
  - out_valid = 1; out_data and out_err are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0, so there is no overlap of transactions.
- red_data holds the last product in every state and changes only in MUL.
- red_done outside WAIT is ignored: no state change, no capture.
- Only one reduction is outstanding at a time. red_start is never asserted while in WAIT.
- Arithmetic:
  - Operand compare and subtract use unsigned Q_WIDTH.
  - The product is 2·Q_WIDTH bits, zero-extended to DATA_WIDTH.
  - The watchdog counter is clog2(TIMEOUT_CYCLES) bits and does not wrap; it saturates at terminal count.

## Timing
- Reset values:
  - State IDLE.
  - in_ready = 1 in the first cycle after reset.
  - red_start = 0, red_data = 0.
  - out_valid = 0, out_data = 0, out_err = 0.
  - Counter = 0.
- Reset in any state, including WAIT, abandons the transaction in the next cycle. The system resets the reducer in the same cycle.
- Launch latency: operand handshake at edge E0, state PRE after E0, MUL after E1, ISSUE (red_start high) after E2, so the reducer samples at E3.
- Result latency: out_valid rises one cycle after the cycle in which red_done = 1. Total latency is 4 + reducer latency cycles.
- Timeout: out_valid with out_err = 1 in the cycle after WAIT cycle TIMEOUT_CYCLES.
- Throughput: one pair per (reducer latency + 5) cycles when out_ready is held high.
- Back-to-back: with out_ready = 1, the OUT→IDLE→PRE path accepts a new pair in the IDLE cycle after the OUT handshake.

## Structure
- Shared package (mod_q_pkg) holds:
  - Q = 23'd8380417 and Q_WIDTH.
  - The state enum.
  - TIMEOUT_CYCLES default.
- One natural sub-module, mod_q_correct: a combinational conditional subtract (x ≥ q ? x − q : x). It is instantiated twice in PRE and reused by future NTT blocks.
- The multiplier is inline (single registered multiply). The reducer itself is external, connected through the red_* ports.

## Test plan
- a = 3, b = 5, with a reducer model of latency 5 → red_data = 15 with red_start high for 1 cycle, then out_data = 15, out_err = 0.
- a = b = 8380416 → red_data = 70231372333056, out_data = 1.
- a = 8388607, b = 1 → corrected a = 8190, red_data = 8190, out_data = 8190.
- Reducer model never asserts done → out_valid in the cycle after WAIT cycle 16, with out_err = 1 and out_data = 0. A following valid transaction has out_err = 0.
- Hold out_ready low for 5 cycles in OUT → out_data stable, in_ready = 0, no red_start. Inject a stray red_done during OUT → ignored.
- Assert rst during WAIT → the next cycle shows IDLE with all outputs at reset values. A late red_done is ignored, and a new pair completes normally.

Source files
------------

// File: rtl/mod_q_pkg.sv
// Shared constants and types for arithmetic modulo the Dilithium prime q.
package mod_q_pkg;

  localparam int Q_WIDTH = 23;
  localparam logic [Q_WIDTH-1:0] Q = 23'd8380417;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    MUL   = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5
  } state_t;

endpackage

// File: rtl/mod_q_correct.sv
// Single conditional subtract that folds any 23-bit value into [0, q).
// One subtraction is enough because 2^23 < 2q.
module mod_q_correct
  import mod_q_pkg::*;
(
  input  logic [Q_WIDTH-1:0] x,
  output logic [Q_WIDTH-1:0] y
);

  assign y = (x >= Q) ? (x - Q) : x;

endmodule

// File: rtl/modular_mult_initiator.sv
// Accepts operand pairs, range-corrects them, forms the 46-bit product,
// hands it to an external Barrett reducer with a start pulse, and returns
// the reduced value (or a watchdog error) downstream.
module modular_mult_initiator #(
  parameter int Q_WIDTH        = 23,
  parameter int DATA_WIDTH     = 48,
  parameter int TIMEOUT_CYCLES = mod_q_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Q_WIDTH-1:0]    in_a,
  input  logic [Q_WIDTH-1:0]    in_b,
  output logic                  red_start,
  output logic [DATA_WIDTH-1:0] red_data,
  input  logic                  red_done,
  input  logic [Q_WIDTH-1:0]    red_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q_WIDTH-1:0]    out_data,
  output logic                  out_err
);
  import mod_q_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;

  logic [Q_WIDTH-1:0]   op_a_p0;
  logic [Q_WIDTH-1:0]   op_b_p0;
  logic [Q_WIDTH-1:0]   corr_a;
  logic [Q_WIDTH-1:0]   corr_b;
  logic [Q_WIDTH-1:0]   op_a_p1;
  logic [Q_WIDTH-1:0]   op_b_p1;
  logic [2*Q_WIDTH-1:0] prod;

  // Stage p0 -> p1: range correction of the captured operands
  mod_q_correct u_corr_a (
    .x (op_a_p0),
    .y (corr_a)
  );

  mod_q_correct u_corr_b (
    .x (op_b_p0),
    .y (corr_b)
  );

  // Stage p1 -> product: full-width unsigned multiply of corrected operands
  assign prod = {{Q_WIDTH{1'b0}}, op_a_p1} * {{Q_WIDTH{1'b0}}, op_b_p1};

  // Operand pipeline registers; never observed outside, so left unreset
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      op_a_p0 <= in_a;
      op_b_p0 <= in_b;
    end
    if (state == PRE) begin
      op_a_p1 <= corr_a;
      op_b_p1 <= corr_b;
    end
  end

  // Transaction sequencer with registered handshake, launch and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      red_start <= 1'b0;
      red_data  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            state    <= PRE;
          end
        end
        PRE: begin
          state <= MUL;
        end
        MUL: begin
          red_data  <= DATA_WIDTH'(prod);
          red_start <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          red_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt != CNT_TERM) begin
            cnt <= cnt + 1'b1;
          end
          // A completion in the terminal cycle still counts as a success.
          if (red_done) begin
            out_data  <= red_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (cnt == CNT_TERM) begin
            out_data  <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
